accumulator_unit: RTL and testbench
===================================

// Module: accumulator_unit
// PURPOSE
//  Accumulator + ALU stage for the 8-bit datapath. Consumes the register-file read value as
//  operand and holds the accumulator that drives the register-file write-data input
//  (accumulator_input). Executes one opcode per valid/ready handshake.
//  Single-cycle ops for arithmetic/logic/shift; multi-cycle shift-add multiply.
// PARAMETERS
//  WIDTH     8   datapath width: accumulator, operand and mul_hi
//  MUL_CYCLES  WIDTH   multiply iterations (localparam, not overridable)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  op_valid  in   1      opcode/operand presented this cycle
//  op_ready  out  1      unit can accept; high only in IDLE
//  opcode    in   4      operation (acc_pkg::opcode_e)
//  operand   in   WIDTH  register-file read value
//  acc       out  WIDTH  accumulator; feeds register-file write data
//  mul_hi    out  WIDTH  high half of last MUL product
//  flag_z    out  1      result == 0
//  flag_n    out  1      result[WIDTH-1]
//  flag_c    out  1      carry/borrow/shift-out (see BEHAVIOUR)
//  done      out  1      1-cycle pulse: an accepted op has retired
//  illegal   out  1      1-cycle pulse with done: opcode was undefined
// BEHAVIOUR
//  Reset: acc=0, mul_hi=0, flags=0, done=0, illegal=0, state=IDLE, iteration count=0.
//   Reset aborts an in-flight MUL with no partial update. op_valid is ignored while rst=1.
//  Accept: op_valid & op_ready on a rising edge. FSM states: IDLE, MUL.
//  Single-cycle ops: acc/flags update on the accept edge. done=1 in the next cycle.
//   Stay in IDLE, so back-to-back accepts every cycle are legal.
//  Opcodes:
//   0 NOP   no change
//   1 LD    acc=operand, C=0
//   2 ADD   acc+operand, C=carry-out
//   3 SUB   acc-operand, C=borrow (operand>acc)
//   4 AND / 5 OR / 6 XOR   C=0
//   7 SHL   C=old acc[MSB], shift in 0
//   8 SHR   logical, C=old acc[0]
//   9 INC   C=carry
//   A DEC   C=borrow
//   B CLR   acc=0, C=0
//   C MUL   multiply
//   D-F     illegal: acc/flags unchanged, done+illegal pulse
//  Flag rules: Z and N computed from the new acc for every op except NOP and illegal, which
//   leave all flags unchanged. Arithmetic is modulo 2^WIDTH; the carry is bit WIDTH of the
//   (WIDTH+1)-bit sum.
//  MUL (ACC_MUL_EN defined):
//   Accept edge: go to MUL, latch multiplicand=acc and multiplier=operand, clear product, cnt=0.
//   Each cycle: one shift-add iteration. On iteration MUL_CYCLES (cnt==MUL_CYCLES-1 edge):
//    acc=product[WIDTH-1:0], mul_hi=product[2W-1:W], Z/N from acc, C=(mul_hi!=0), go to IDLE.
//   done is high the cycle after that edge, i.e. MUL_CYCLES cycles after accept.
//   op_ready=0 throughout MUL; op_valid in that window is not consumed (source holds it).
// CONFIGURATION
//  ACC_MUL_EN defined: MUL implemented as above; mul_hi updated only by MUL.
//  ACC_MUL_EN undefined: no MUL state or datapath; opcode C is treated as illegal.
//   mul_hi is tied to 0.
// STRUCTURE
//  acc_pkg: opcode_e (4-bit enum, values above), state_e {IDLE, MUL},
//   WIDTH-independent opcode constants.
//  One sub-module, acc_alu_comb: pure combinational single-cycle result and flags from
//   (opcode, acc, operand, old flags). Top holds FSM, registers and the multiplier iteration.
// TESTING
//  1. rst=1 for 2 cycles mid-stream -> acc=0, all flags 0, op_ready=1, done=0.
//  2. LD 0xF0 then ADD 0x20 back-to-back -> acc=0x10, C=1, Z=0, N=0.
//     done high on both following cycles.
//  3. LD 0x05; SUB 0x05 -> acc=0, Z=1, C=0. Then SUB 0x01 -> acc=0xFF, N=1, C=1.
//  4. ACC_MUL_EN defined: LD 0x0C; MUL 0x15 -> op_ready low 8 cycles.
//     Then acc=0xFC, mul_hi=0x00, C=0, done 8 cycles after accept.
//     Then LD 0xFF; MUL 0xFF -> acc=0x01, mul_hi=0xFE, C=1.
//  5. Assert rst at iteration 4 of MUL -> acc=0, mul_hi=0, state IDLE next cycle, no done pulse.
//  6. Opcode 0xE (and 0xC without ACC_MUL_EN) with acc=0x33 -> done+illegal 1 cycle;
//     acc and flags unchanged.

Source files
------------

// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : acc_pkg
//  Purpose  : Shared types for the accumulator/ALU stage: opcode encoding,
//             control FSM states and width-independent opcode constants.
//  Config   : ACC_MUL_EN (see accumulator_unit) selects whether OP_MUL is
//             implemented or treated as an undefined opcode.
//  Revision : 1.0  initial release
// ============================================================================
package acc_pkg;

  localparam int unsigned OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 4'h0,
    OP_LD  = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8,
    OP_INC = 4'h9,
    OP_DEC = 4'hA,
    OP_CLR = 4'hB,
    OP_MUL = 4'hC
  } opcode_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage : acc_pkg
`default_nettype wire

// File: rtl/acc_alu_comb.sv
`default_nettype none
// ============================================================================
//  Module   : acc_alu_comb
//  Purpose  : Purely combinational single-cycle ALU. Produces the next
//             accumulator value and flags from opcode, accumulator, operand
//             and current flags. MUL and D-F report illegal here; the top
//             intercepts MUL when the multiplier is built in.
//  Revision : 1.0  initial release
// ============================================================================
module acc_alu_comb
  import acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [WIDTH-1:0]    i_acc,
  input  logic [WIDTH-1:0]    i_operand,
  input  logic                i_z,
  input  logic                i_n,
  input  logic                i_c,
  output logic [WIDTH-1:0]    o_acc,
  output logic                o_z,
  output logic                o_n,
  output logic                o_c,
  output logic                o_illegal
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_upd;

  // Decode opcode into the new accumulator value; NOP/illegal keep everything
  always_comb begin
    w_sum     = '0;
    w_res     = i_acc;
    w_upd     = 1'b1;
    o_c       = i_c;
    o_illegal = 1'b0;
    case (opcode_e'(i_opcode))
      OP_NOP: w_upd = 1'b0;
      OP_LD: begin
        w_res = i_operand;
        o_c   = 1'b0;
      end
      OP_ADD: begin
        w_sum = {1'b0, i_acc} + {1'b0, i_operand};
        w_res = w_sum[WIDTH-1:0];
        o_c   = w_sum[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (operand > acc)
        w_sum = {1'b0, i_acc} - {1'b0, i_operand};
        w_res = w_sum[WIDTH-1:0];
        o_c   = w_sum[WIDTH];
      end
      OP_AND: begin
        w_res = i_acc & i_operand;
        o_c   = 1'b0;
      end
      OP_OR: begin
        w_res = i_acc | i_operand;
        o_c   = 1'b0;
      end
      OP_XOR: begin
        w_res = i_acc ^ i_operand;
        o_c   = 1'b0;
      end
      OP_SHL: begin
        w_res = {i_acc[WIDTH-2:0], 1'b0};
        o_c   = i_acc[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, i_acc[WIDTH-1:1]};
        o_c   = i_acc[0];
      end
      OP_INC: begin
        w_sum = {1'b0, i_acc} + (WIDTH+1)'(1);
        w_res = w_sum[WIDTH-1:0];
        o_c   = w_sum[WIDTH];
      end
      OP_DEC: begin
        w_sum = {1'b0, i_acc} - (WIDTH+1)'(1);
        w_res = w_sum[WIDTH-1:0];
        o_c   = w_sum[WIDTH];
      end
      OP_CLR: begin
        w_res = '0;
        o_c   = 1'b0;
      end
      default: begin
        w_upd     = 1'b0;
        o_illegal = 1'b1;
      end
    endcase
  end

  // Z/N follow the new accumulator only when the op actually produced one
  always_comb begin
    o_acc = i_acc;
    o_z   = i_z;
    o_n   = i_n;
    if (w_upd) begin
      o_acc = w_res;
      o_z   = (w_res == '0);
      o_n   = w_res[WIDTH-1];
    end
  end

endmodule : acc_alu_comb
`default_nettype wire

// File: rtl/accumulator_unit.sv
`default_nettype none
// ============================================================================
//  Module   : accumulator_unit
//  Purpose  : Accumulator + ALU stage of the 8-bit datapath. One opcode per
//             valid/ready handshake; single-cycle ALU ops, optional
//             WIDTH-iteration shift-add multiplier.
//  Config   : `define ACC_MUL_EN to build the multiplier. Without it opcode
//             0xC retires as illegal and mul_hi is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module accumulator_unit
  import acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    operand,
  output logic [WIDTH-1:0]    acc,
  output logic [WIDTH-1:0]    mul_hi,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_c,
  output logic                done,
  output logic                illegal
);

  logic [WIDTH-1:0] r_acc;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_done;
  logic             r_illegal;

  logic [WIDTH-1:0] w_alu_acc;
  logic             w_alu_z;
  logic             w_alu_n;
  logic             w_alu_c;
  logic             w_alu_illegal;
  logic             w_accept;

  acc_alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_opcode  (opcode),
    .i_acc     (r_acc),
    .i_operand (operand),
    .i_z       (r_z),
    .i_n       (r_n),
    .i_c       (r_c),
    .o_acc     (w_alu_acc),
    .o_z       (w_alu_z),
    .o_n       (w_alu_n),
    .o_c       (w_alu_c),
    .o_illegal (w_alu_illegal)
  );

  assign w_accept = op_valid & op_ready;

`ifdef ACC_MUL_EN
  localparam int MUL_CYCLES = WIDTH;
  localparam int CNT_W      = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mul_hi;
  logic [2*WIDTH-1:0] w_prod_next;

  // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

  // Control FSM with accumulator, flag, multiplier and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_mul_hi  <= '0;
      r_acc     <= '0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_c       <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (opcode_e'(opcode) == OP_MUL) begin
              r_state  <= MUL;
              r_mcand  <= {{WIDTH{1'b0}}, r_acc};
              r_mplier <= operand;
              r_prod   <= '0;
              r_cnt    <= '0;
            end else begin
              r_acc     <= w_alu_acc;
              r_z       <= w_alu_z;
              r_n       <= w_alu_n;
              r_c       <= w_alu_c;
              r_done    <= 1'b1;
              r_illegal <= w_alu_illegal;
            end
          end
        end
        MUL: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= w_prod_next[WIDTH-1:0];
            r_mul_hi <= w_prod_next[2*WIDTH-1:WIDTH];
            r_z      <= (w_prod_next[WIDTH-1:0] == '0);
            r_n      <= w_prod_next[WIDTH-1];
            r_c      <= (w_prod_next[2*WIDTH-1:WIDTH] != '0);
            r_done   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign op_ready = (r_state == IDLE);
  assign mul_hi   = r_mul_hi;
`else
  // Single-cycle ops only: every accepted opcode retires on the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_c       <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= w_accept;
      r_illegal <= w_accept & w_alu_illegal;
      if (w_accept) begin
        r_acc <= w_alu_acc;
        r_z   <= w_alu_z;
        r_n   <= w_alu_n;
        r_c   <= w_alu_c;
      end
    end
  end

  assign op_ready = 1'b1;
  assign mul_hi   = '0;
`endif

  assign acc     = r_acc;
  assign flag_z  = r_z;
  assign flag_n  = r_n;
  assign flag_c  = r_c;
  assign done    = r_done;
  assign illegal = r_illegal;

endmodule : accumulator_unit
`default_nettype wire

// File: tb/tb_accumulator_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accumulator_unit
//  Purpose  : Self-checking bench for accumulator_unit: directed scenarios
//             followed by random opcodes against an arithmetic reference model.
//             Honors ACC_MUL_EN the same way as the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_accumulator_unit;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] opcode;
  logic [7:0] operand;
  logic [7:0] acc;
  logic [7:0] mul_hi;
  logic       flag_z;
  logic       flag_n;
  logic       flag_c;
  logic       done;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_acc;
  int m_hi;
  bit m_z;
  bit m_n;
  bit m_c;

  accumulator_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .opcode   (opcode),
    .operand  (operand),
    .acc      (acc),
    .mul_hi   (mul_hi),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .done     (done),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_hi = 0; m_z = 0; m_n = 0; m_c = 0;
  endtask

  // Reference behaviour derived from the opcode table with plain integer math
  task automatic model(input int op, input int b, output bit ill);
    int a;
    int r;
    int p;
    bit upd;
    a   = m_acc;
    r   = a;
    upd = 1;
    ill = 0;
    case (op)
      0:  upd = 0;
      1:  begin r = b;                 m_c = 0;            end
      2:  begin r = (a + b) % 256;     m_c = (a + b) > 255; end
      3:  begin r = (a - b + 256) % 256; m_c = (b > a);    end
      4:  begin r = a & b;             m_c = 0;            end
      5:  begin r = a | b;             m_c = 0;            end
      6:  begin r = a ^ b;             m_c = 0;            end
      7:  begin r = (a * 2) % 256;     m_c = (a >= 128);   end
      8:  begin r = a / 2;             m_c = (a % 2) == 1; end
      9:  begin r = (a + 1) % 256;     m_c = (a == 255);   end
      10: begin r = (a + 255) % 256;   m_c = (a == 0);     end
      11: begin r = 0;                 m_c = 0;            end
`ifdef ACC_MUL_EN
      12: begin
        p    = a * b;
        r    = p % 256;
        m_hi = p / 256;
        m_c  = (m_hi != 0);
      end
`endif
      default: begin upd = 0; ill = 1; end
    endcase
    if (upd) begin
      m_acc = r;
      m_z   = (r == 0);
      m_n   = (r >= 128);
    end
  endtask

  task automatic chk_state(input string tag, input bit exp_done, input bit exp_ill);
    chk({tag, "_acc"},     acc,     m_acc);
    chk({tag, "_mulhi"},   mul_hi,  m_hi);
    chk({tag, "_z"},       flag_z,  m_z);
    chk({tag, "_n"},       flag_n,  m_n);
    chk({tag, "_c"},       flag_c,  m_c);
    chk({tag, "_done"},    done,    exp_done);
    chk({tag, "_illegal"}, illegal, exp_ill);
  endtask

  // Present one opcode at the falling edge, leave op_valid asserted afterwards
  task automatic issue(input logic [3:0] op, input logic [7:0] val, input bit hold);
    bit ill;
    @(negedge clk);
    op_valid = 1'b1;
    opcode   = op;
    operand  = val;
    chk("ready_before_accept", op_ready, 1);
    @(posedge clk);
    #1;
`ifdef ACC_MUL_EN
    if (op == 4'hC) begin
      if (hold) begin
        opcode  = 4'h1;
        operand = 8'hAA;
      end else begin
        op_valid = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
        chk("mul_busy_ready", op_ready, 0);
        chk("mul_busy_done",  done,     0);
        chk("mul_busy_acc",   acc,      m_acc);
        @(posedge clk);
        #1;
      end
      chk("mul_ready_after", op_ready, 1);
    end
`endif
    model(op, val, ill);
    chk_state("op", 1'b1, ill);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_done",    done,    0);
    chk("idle_illegal", illegal, 0);
    chk("idle_acc",     acc,     m_acc);
  endtask

  initial begin
    rst      = 1'b1;
    op_valid = 1'b0;
    opcode   = 4'h0;
    operand  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 1'b0, 1'b0);
    chk("reset_ready", op_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // LD then ADD back-to-back: carry out, done on both cycles
    issue(4'h1, 8'hF0, 0);
    issue(4'h2, 8'h20, 0);
    chk("t2_acc", acc, 8'h10);
    chk("t2_c",   flag_c, 1);
    chk("t2_z",   flag_z, 0);
    chk("t2_n",   flag_n, 0);

    // SUB to zero, then borrow through zero
    issue(4'h1, 8'h05, 0);
    issue(4'h3, 8'h05, 0);
    chk("t3_zero_acc", acc, 8'h00);
    chk("t3_zero_z",   flag_z, 1);
    chk("t3_zero_c",   flag_c, 0);
    issue(4'h3, 8'h01, 0);
    chk("t3_borrow_acc", acc, 8'hFF);
    chk("t3_borrow_n",   flag_n, 1);
    chk("t3_borrow_c",   flag_c, 1);

    // reset mid-stream with op_valid held high: the op must not be consumed
    @(negedge clk);
    rst      = 1'b1;
    op_valid = 1'b1;
    opcode   = 4'h1;
    operand  = 8'h77;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk_state("midrst", 1'b0, 1'b0);
      chk("midrst_ready", op_ready, 1);
    end
    @(negedge clk);
    rst      = 1'b0;
    op_valid = 1'b0;
    idle_cycle();

    // undefined opcode leaves acc and flags intact
    issue(4'h1, 8'h33, 0);
    issue(4'hE, 8'h99, 0);
    chk("t6_acc", acc, 8'h33);
    chk("t6_illegal", illegal, 1);
    idle_cycle();
`ifndef ACC_MUL_EN
    issue(4'hC, 8'h12, 0);
    chk("t6_mul_illegal", illegal, 1);
    chk("t6_mul_acc", acc, 8'h33);
    chk("t6_mulhi_tied", mul_hi, 8'h00);
    idle_cycle();
`endif

`ifdef ACC_MUL_EN
    // multiply while the source holds a follow-up LD through the busy window
    issue(4'h1, 8'h0C, 0);
    issue(4'hC, 8'h15, 1);
    chk("t4_acc", acc, 8'hFC);
    chk("t4_hi",  mul_hi, 8'h00);
    chk("t4_c",   flag_c, 0);
    begin
      bit ill;
      @(posedge clk);
      #1;
      model(1, 8'hAA, ill);
      chk_state("t4_held_ld", 1'b1, ill);
    end
    issue(4'h1, 8'hFF, 0);
    issue(4'hC, 8'hFF, 0);
    chk("t4b_acc", acc, 8'h01);
    chk("t4b_hi",  mul_hi, 8'hFE);
    chk("t4b_c",   flag_c, 1);

    // reset at iteration 4 of a multiply: no done, everything cleared
    issue(4'h1, 8'h0B, 0);
    @(negedge clk);
    opcode  = 4'hC;
    operand = 8'h0D;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk_state("t5_rst", 1'b0, 1'b0);
    chk("t5_ready", op_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("t5_no_done", done, 0);
    end
`endif

    // random opcode stream with occasional idle gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle();
      end else begin
        issue(4'($urandom_range(0, 15)), 8'($urandom), 0);
      end
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_accumulator_unit
`default_nettype wire
